alu_writeback: RTL and testbench
================================

# alu_writeback

Result write-back stage directly downstream of the ALU. It captures the ALU result pair (low word, high word) when the ALU signals completion. It then gains the shared data bus through a request/grant handshake and writes the low word, plus the high word for wide-result commands, to the destination address. Completion and error status go back to the sequencer.

## Interface
- DATA_W, 32, data word width (low and high result words).
- ADDR_W, 32, bus address width.
- HI_MASK, 16'h0000, bit n set = command code n also writes the high word.
- TIMEOUT, 255, maximum cycles spent waiting for bus_ack per word (1..2^16-1).

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- alu_done  in  1  one-cycle pulse; result inputs valid this cycle.
- cmd_code  in  4  command code of the completed instruction.
- dst_addr  in  ADDR_W  destination address of the low word.
- dst_lo  in  DATA_W  ALU low result word.
- dst_hi  in  DATA_W  ALU high result word.
- bus_req  out  1  bus request, held from REQ through the last write.
- bus_gnt  in  1  bus grant from arbiter.
- bus_we  out  1  write strobe; high in the WR_LO and WR_HI states.
- bus_addr  out  ADDR_W  write address (0 when bus_we is low).
- bus_wdata  out  DATA_W  write data (0 when bus_we is low).
- bus_ack  in  1  target accepted the current write.
- busy  out  1  high in every state except IDLE.
- wb_done  out  1  one-cycle pulse: write-back finished.
- wb_err  out  1  one-cycle pulse with wb_done when a write timed out.
- overrun  out  1  sticky: alu_done arrived while not IDLE.

## Operation
- States: IDLE, REQ, WR_LO, WR_HI, DONE.
- IDLE: if alu_done=1:
  - latch cmd_code, dst_addr, dst_lo, dst_hi.
  - latch hi_en = HI_MASK[cmd_code].
  - go to REQ.
- REQ: bus_req=1. When bus_gnt=1 is sampled, clear the timeout counter and go to WR_LO. Otherwise stay; there is no timeout in REQ.
- WR_LO: bus_req=1, bus_we=1, bus_addr=latched addr, bus_wdata=latched lo.
  - On bus_ack=1: if hi_en, go to WR_HI and clear the counter; else go to DONE.
- WR_HI: same drive, with bus_addr = latched addr + 1 modulo 2^ADDR_W (all-ones wraps to 0) and bus_wdata = latched hi.
  - On bus_ack=1, go to DONE.
- Timeout:
  - The counter increments each WR_LO/WR_HI cycle without ack.
  - When the counter reaches TIMEOUT with no ack, set the error flag and go to DONE. A timeout in WR_LO skips WR_HI.
- DONE: bus_req=0, bus_we=0, wb_done=1, wb_err=error flag. Clear the error flag and return to IDLE.
- bus_gnt is sampled only in REQ. A grant drop during the WR states is ignored.
- bus_ack is ignored outside the WR states.
- alu_done outside IDLE, including in DONE:
  - the new result is dropped and overrun is set.
  - overrun is cleared only by rst.
- Reset (asynchronous, any state):
  - state goes to IDLE; all outputs go to 0.
  - latched registers, counter and flags clear.
  - No partial write completes. A write in flight is abandoned.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational input-to-output path.
- Low-only, with grant and ack both high immediately:
  - edge 0 samples alu_done.
  - REQ in cycle 1, WR_LO in cycle 2, DONE in cycle 3.
  - wb_done rises 3 cycles after the alu_done edge.
- With hi_en: wb_done rises 4 cycles after the alu_done edge.
- Each cycle of grant delay or ack delay adds 1 cycle.
- Timeout: WR_LO with no ack lasts TIMEOUT+1 cycles, then DONE.
- Back-to-back: the next alu_done is accepted at the earliest in the cycle after DONE, when the state is IDLE.
- busy is high from the cycle after the accepted alu_done through the DONE cycle inclusive.

## Test plan
- Low-only write:
  - Stimulus: HI_MASK=0, cmd 1, addr 0x100, lo 0xDEADBEEF, gnt/ack tied 1.
  - Response: one write of 0xDEADBEEF at 0x100; wb_done 3 cycles after alu_done; wb_err=0.
- Wide write:
  - Stimulus: HI_MASK bit 3 set, cmd 3, addr 0xFFFFFFFF, lo 0x1, hi 0x2.
  - Response: writes (0xFFFFFFFF, 0x1) then (0x00000000, 0x2); wb_done at +4 cycles.
- Stalls:
  - Stimulus: grant delayed 5 cycles, ack delayed 2 cycles per word.
  - Response: bus_req stays high continuously; addr/data stable while we=1; wb_done at +3+5+2 cycles for low-only.
- Timeout:
  - Stimulus: TIMEOUT=4, ack never asserted, wide cmd.
  - Response: WR_LO held 5 cycles; no WR_HI; wb_done and wb_err pulse together; next command works normally.
- Overrun:
  - Stimulus: second alu_done (lo 0x55) while in WR_LO, and another during DONE.
  - Response: overrun=1 and stays 1; only the first result is written; state and latched data are unchanged.
- Reset mid-write:
  - Stimulus: rst asserted asynchronously mid-cycle in WR_HI.
  - Response: all outputs 0 before the next clock edge; state IDLE; no wb_done; overrun cleared.

Source files
------------

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback
// Description : Result write-back stage behind the ALU. Captures the ALU
//               result pair on alu_done, requests the shared data bus, then
//               writes the low word (and optionally the high word at
//               addr+1) with a per-word ack timeout. Reports completion,
//               timeout error and a sticky overrun flag to the sequencer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   alu_done   in   one-cycle pulse, result inputs valid
//   cmd_code   in   [3:0] command code of completed instruction
//   dst_addr   in   [ADDR_W-1:0] destination address of low word
//   dst_lo     in   [DATA_W-1:0] ALU low result word
//   dst_hi     in   [DATA_W-1:0] ALU high result word
//   bus_req    out  bus request, REQ through last write
//   bus_gnt    in   bus grant (sampled only in REQ)
//   bus_we     out  write strobe in WR_LO / WR_HI
//   bus_addr   out  [ADDR_W-1:0] write address, 0 when bus_we low
//   bus_wdata  out  [DATA_W-1:0] write data, 0 when bus_we low
//   bus_ack    in   target accepted current write
//   busy       out  high in every state except IDLE
//   wb_done    out  one-cycle completion pulse
//   wb_err     out  one-cycle pulse with wb_done on write timeout
//   overrun    out  sticky: alu_done seen while not IDLE
// ============================================================================
module alu_writeback #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter logic [15:0] HI_MASK = 16'h0000,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_done,
  input  logic [3:0]        cmd_code,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] dst_lo,
  input  logic [DATA_W-1:0] dst_hi,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              wb_done,
  output logic              wb_err,
  output logic              overrun
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  // The command code itself is not needed after capture; only whether it
  // selects a wide write, so that single bit is all that is held.
  logic              hi_en_q, hi_en_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      hi_en_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      hi_en_q   <= hi_en_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    hi_en_d   = hi_en_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    // A result arriving while a write-back is in progress (DONE included)
    // is dropped; the sequencer learns of it only through this sticky flag.
    overrun_d = overrun_q | (alu_done && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (alu_done) begin
          addr_d  = dst_addr;
          lo_d    = dst_lo;
          hi_d    = dst_hi;
          hi_en_d = HI_MASK[cmd_code];
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = ST_WR_LO;
        end
      end

      ST_WR_LO: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          if (hi_en_q) begin
            cnt_d   = '0;
            state_d = ST_WR_HI;
          end else begin
            state_d = ST_DONE;
          end
        end else if (cnt_q == C_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_WR_HI: begin
        if (bus_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q == C_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded purely from registered state, so an asynchronous reset
  // drives them all to zero immediately.
  // --------------------------------------------------------------------------
  logic w_wr_lo;
  logic w_wr_hi;

  assign w_wr_lo   = (state_q == ST_WR_LO);
  assign w_wr_hi   = (state_q == ST_WR_HI);

  assign bus_req   = (state_q == ST_REQ) | w_wr_lo | w_wr_hi;
  assign bus_we    = w_wr_lo | w_wr_hi;
  // High word goes to the next address; the add wraps naturally at ADDR_W.
  assign bus_addr  = w_wr_lo ? addr_q :
                     w_wr_hi ? (addr_q + ADDR_W'(1)) : '0;
  assign bus_wdata = w_wr_lo ? lo_q :
                     w_wr_hi ? hi_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign wb_done   = (state_q == ST_DONE);
  assign wb_err    = (state_q == ST_DONE) & err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_writeback
// Description : Directed self-checking bench for alu_writeback. The DUT is
//               built with HI_MASK bit 3 set (cmd 3 is wide, cmd 1 is not)
//               and TIMEOUT=4. Each step advances one clock and samples 1ns
//               after the rising edge; cycle 1 is the cycle after the edge
//               that samples alu_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback;

  logic        clk;
  logic        rst;
  logic        alu_done;
  logic [3:0]  cmd_code;
  logic [31:0] dst_addr;
  logic [31:0] dst_lo;
  logic [31:0] dst_hi;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        busy;
  logic        wb_done;
  logic        wb_err;
  logic        overrun;

  int checks;
  int failures;

  alu_writeback #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .HI_MASK (16'h0008),
    .TIMEOUT (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .alu_done  (alu_done),
    .cmd_code  (cmd_code),
    .dst_addr  (dst_addr),
    .dst_lo    (dst_lo),
    .dst_hi    (dst_hi),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .busy      (busy),
    .wb_done   (wb_done),
    .wb_err    (wb_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one result; returns 1ns into cycle 1.
  task automatic launch(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] lo, input logic [31:0] hi);
    cmd_code = c;
    dst_addr = a;
    dst_lo   = lo;
    dst_hi   = hi;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    alu_done = 1'b0;
    cmd_code = '0;
    dst_addr = '0;
    dst_lo   = '0;
    dst_hi   = '0;
    bus_gnt  = 1'b0;
    bus_ack  = 1'b0;
    step();
    step();

    // ---------------- reset state ----------------
    chk("rst_req",  bus_req,  1'b0);
    chk("rst_we",   bus_we,   1'b0);
    chk("rst_busy", busy,     1'b0);
    chk("rst_done", wb_done,  1'b0);
    chk("rst_ovr",  overrun,  1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    rst = 1'b0;
    step();

    // ---------------- low-only write ----------------
    bus_gnt = 1'b1;
    bus_ack = 1'b1;
    launch(4'd1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678);
    chk("lo_c1_busy", busy,    1'b1);
    chk("lo_c1_req",  bus_req, 1'b1);
    chk("lo_c1_we",   bus_we,  1'b0);
    step();
    chk("lo_c2_we",   bus_we,    1'b1);
    chk("lo_c2_addr", bus_addr,  32'h0000_0100);
    chk("lo_c2_data", bus_wdata, 32'hDEAD_BEEF);
    chk("lo_c2_done", wb_done,   1'b0);
    step();
    chk("lo_c3_done", wb_done, 1'b1);
    chk("lo_c3_err",  wb_err,  1'b0);
    chk("lo_c3_we",   bus_we,  1'b0);
    chk("lo_c3_req",  bus_req, 1'b0);
    chk("lo_c3_busy", busy,    1'b1);
    step();
    chk("lo_c4_busy", busy,    1'b0);
    chk("lo_c4_done", wb_done, 1'b0);

    // ---------------- wide write with address wrap ----------------
    launch(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002);
    chk("wd_c1_req", bus_req, 1'b1);
    step();
    chk("wd_c2_addr", bus_addr,  32'hFFFF_FFFF);
    chk("wd_c2_data", bus_wdata, 32'h0000_0001);
    step();
    chk("wd_c3_we",   bus_we,    1'b1);
    chk("wd_c3_addr", bus_addr,  32'h0000_0000);
    chk("wd_c3_data", bus_wdata, 32'h0000_0002);
    chk("wd_c3_done", wb_done,   1'b0);
    step();
    chk("wd_c4_done", wb_done, 1'b1);
    chk("wd_c4_err",  wb_err,  1'b0);
    step();

    // ---------------- grant and ack stalls ----------------
    bus_gnt = 1'b0;
    bus_ack = 1'b0;
    launch(4'd1, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      if (c <= 9) chk($sformatf("st_c%0d_req", c), bus_req, 1'b1);
      chk($sformatf("st_c%0d_we", c), bus_we, (c >= 7 && c <= 9) ? 1'b1 : 1'b0);
      if (c >= 7 && c <= 9) begin
        chk($sformatf("st_c%0d_addr", c), bus_addr,  32'h0000_0200);
        chk($sformatf("st_c%0d_data", c), bus_wdata, 32'hA5A5_A5A5);
      end
      chk($sformatf("st_c%0d_done", c), wb_done, (c == 10) ? 1'b1 : 1'b0);
      if (c == 6) bus_gnt = 1'b1;
      if (c == 9) bus_ack = 1'b1;
      if (c < 10) step();
    end
    step();

    // ---------------- timeout on low word of a wide command ----------------
    bus_gnt = 1'b1;
    bus_ack = 1'b0;
    launch(4'd3, 32'h0000_0500, 32'h0000_00AA, 32'h0000_00BB);
    for (int c = 2; c <= 7; c++) begin
      step();
      if (c <= 6) begin
        chk($sformatf("to_c%0d_we", c),   bus_we,   1'b1);
        chk($sformatf("to_c%0d_addr", c), bus_addr, 32'h0000_0500);
        chk($sformatf("to_c%0d_done", c), wb_done,  1'b0);
      end else begin
        chk("to_c7_done", wb_done, 1'b1);
        chk("to_c7_err",  wb_err,  1'b1);
        chk("to_c7_we",   bus_we,  1'b0);
      end
    end
    step();
    chk("to_idle_busy", busy, 1'b0);

    // next command after timeout behaves normally
    bus_ack = 1'b1;
    launch(4'd1, 32'h0000_0600, 32'h0000_0CCC, 32'h0);
    step();
    chk("to2_c2_data", bus_wdata, 32'h0000_0CCC);
    step();
    chk("to2_c3_done", wb_done, 1'b1);
    chk("to2_c3_err",  wb_err,  1'b0);
    step();

    // ---------------- overrun ----------------
    bus_ack = 1'b0;
    launch(4'd1, 32'h0000_0300, 32'h1111_1111, 32'h0);
    chk("ov_c1_ovr", overrun, 1'b0);
    step();
    // cycle 2, WR_LO: second result arrives
    launch(4'd3, 32'h0000_0400, 32'h0000_0055, 32'h0000_0066);
    chk("ov_c3_ovr",  overrun,   1'b1);
    chk("ov_c3_we",   bus_we,    1'b1);
    chk("ov_c3_addr", bus_addr,  32'h0000_0300);
    chk("ov_c3_data", bus_wdata, 32'h1111_1111);
    bus_ack = 1'b1;
    step();
    chk("ov_c4_done", wb_done, 1'b1);
    // another result during DONE
    launch(4'd1, 32'h0000_0700, 32'h0000_0077, 32'h0);
    chk("ov_c5_busy", busy,    1'b0);
    chk("ov_c5_ovr",  overrun, 1'b1);
    step();
    chk("ov_c6_busy", busy,    1'b0);
    chk("ov_c6_req",  bus_req, 1'b0);
    chk("ov_c6_ovr",  overrun, 1'b1);

    // ---------------- asynchronous reset in WR_HI ----------------
    bus_ack = 1'b0;
    launch(4'd3, 32'h0000_0800, 32'h0000_0101, 32'h0000_0202);
    step();
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("rs_whi_addr", bus_addr, 32'h0000_0801);
    #3;
    rst = 1'b1;
    #1;
    chk("rs_req",   bus_req,   1'b0);
    chk("rs_we",    bus_we,    1'b0);
    chk("rs_addr",  bus_addr,  32'h0);
    chk("rs_data",  bus_wdata, 32'h0);
    chk("rs_busy",  busy,      1'b0);
    chk("rs_done",  wb_done,   1'b0);
    chk("rs_ovr",   overrun,   1'b0);
    step();
    rst = 1'b0;
    bus_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rs_post%0d_done", c), wb_done, 1'b0);
      chk($sformatf("rs_post%0d_busy", c), busy,    1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
